maze_ram: RTL and testbench
===========================

MAZE_RAM -- requirements
Module: maze_ram

Interface
REQ-001 SHALL have parameters: DIM, default 64, cells per row/col; AW, default 6, row/col index width (DIM = 2**AW).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: load_start  in  1  pulse, begin a fresh maze load.
REQ-005 SHALL have ports: load_valid  in  1, load_data  in  1 (1 = wall, 0 = free), load_ready  out  1; valid/ready handshake, row-major, row 0 col 0 first.
REQ-006 SHALL have ports: row, col  in  AW each  cell select from solver.
REQ-007 SHALL have ports: maze_oe  in  1  read enable; maze_we  in  1  mark-visited enable; done  in  1  solver exit found.
REQ-008 SHALL have ports: maze_in  out  1  registered read data to solver (1 = wall).
REQ-009 SHALL have ports: loaded  out  1  maze resident and solver port live; finished  out  1  solver reported done.
REQ-010 SHALL have ports: visited_count  out  2*AW+1  distinct cells marked visited; wall_write_err  out  1  sticky, solver wrote a wall.

Function
REQ-011 SHALL store DIM*DIM cells of 2 bits: 0 free, 1 wall, 2 visited; index = row*DIM + col.
REQ-012 SHALL implement FSM IDLE, LOAD, RUN, FIN; IDLE on reset.
REQ-013 IDLE/FIN -> LOAD on load_start; LOAD clears load address to 0, visited_count to 0, wall_write_err to 0.
REQ-014 LOAD: load_ready = 1; each cycle with load_valid & load_ready writes cell {load_data ? 1 : 0} at load address, address +1.
REQ-015 LOAD -> RUN on cycle accepting cell DIM*DIM-1; load_ready low from next cycle; loaded = 1 in RUN.
REQ-016 load_start during LOAD SHALL restart at address 0; load_start in RUN SHALL be ignored.
REQ-017 RUN read: maze_oe high in cycle N -> maze_in at cycle N+1 = (cell == 1); maze_in holds value until next maze_oe.
REQ-018 RUN write: maze_we high, cell 0 -> cell becomes 2, visited_count +1; cell 2 -> no change, no count; cell 1 -> no write, wall_write_err set.
REQ-019 maze_oe & maze_we same cycle, same cell: maze_in returns pre-write value; write still applied.
REQ-020 RUN -> FIN on done = 1; FIN ignores maze_oe/maze_we; maze_in, visited_count frozen; finished = 1 while in FIN.
REQ-021 done and maze_we same cycle in RUN: write applied, then FIN.
REQ-022 Outside RUN, maze_oe SHALL return maze_in = 1 (solver sees walls), maze_we SHALL be ignored.
REQ-023 row/col are AW bits; no out-of-range address possible; no wrap handling required beyond natural width.
REQ-024 visited_count SHALL saturate at DIM*DIM.

Reset
REQ-025 rst SHALL force IDLE, load_ready 0, loaded 0, finished 0, maze_in 1, visited_count 0, wall_write_err 0, load address 0.
REQ-026 Cell contents SHALL NOT be cleared by rst; they are undefined until a complete LOAD.
REQ-027 rst mid-LOAD or mid-RUN SHALL take effect next edge; partial load discarded (loaded stays 0 until full reload).

Verification
REQ-028 Load 4096 cells, border walls except (0,5) free, interior free; load_valid toggled every other cycle -> exactly 4096 handshakes, loaded rises cycle after last, load_ready falls.
REQ-029 RUN, oe at (0,0) cycle N -> maze_in = 1 at N+1; oe at (0,5) -> maze_in = 0; maze_in unchanged with oe low 5 cycles.
REQ-030 we at (10,10) twice, then (10,11) -> visited_count = 2; oe+we same cycle at (12,12) -> maze_in 0, count 3.
REQ-031 we at wall (0,0) -> wall_write_err = 1, visited_count unchanged, subsequent oe at (0,0) -> maze_in 1.
REQ-032 done pulse -> finished = 1 next cycle; later oe/we ignored, count frozen; load_start -> LOAD, count 0, error cleared.
REQ-033 rst asserted after 2000 load cells -> all outputs at reset values; fresh load_start and full 4096-cell load -> loaded = 1.

Source files
------------

// File: rtl/maze_ram.sv
// Maze cell store for a maze-solving engine: loaded over a valid/ready stream, then
// read and marked visited by the solver through a registered single-cell port.
module maze_ram #(
  parameter int DIM = 64,
  parameter int AW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic            load_data,
  output logic            load_ready,
  input  logic [AW-1:0]   row,
  input  logic [AW-1:0]   col,
  input  logic            maze_oe,
  input  logic            maze_we,
  input  logic            done,
  output logic            maze_in,
  output logic            loaded,
  output logic            finished,
  output logic [2*AW:0]   visited_count,
  output logic            wall_write_err
);

  localparam int CELLS = DIM * DIM;
  localparam int CW    = 2 * AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CELLS);
  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] WALL = 2'd1;
  localparam logic [1:0] SEEN = 2'd2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mem [CELLS];
  logic [1:0]          rd_q;
  logic [2*AW-1:0]     load_addr_q;
  logic [2*AW-1:0]     sel_addr;
  logic                accept, load_begin, load_last;
  logic                wr_pend_q, last_mark_q;
  logic [2*AW-1:0]     wr_addr_q, last_addr_q;
  logic [1:0]          cell_now;
  logic                mark, wall_hit;
  logic                rd_valid_q, hold_q;
  logic [CW-1:0]       cnt_q;
  logic                err_q;

  // DIM is a power of two, so row*DIM + col is just the concatenation.
  assign sel_addr   = {row, col};
  assign load_begin = load_start && (state_q != RUN);
  assign accept     = (state_q == LOAD) && load_valid && !load_start;
  assign load_last  = (load_addr_q == {2*AW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (load_start) state_d = LOAD;
               else if (accept && load_last) state_d = RUN;
      RUN:     if (done) state_d = FIN;
      FIN:     if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == LOAD);
    loaded     = (state_q == RUN);
    finished   = (state_q == FIN);
  end

  // A beat coinciding with a restart pulse is discarded along with the old load.
  always_ff @(posedge clk) begin
    if (rst || load_begin) load_addr_q <= '0;
    else if (accept)       load_addr_q <= load_addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept)    mem[load_addr_q] <= load_data ? WALL : FREE;
    else if (mark) mem[wr_addr_q]   <= SEEN;
    rd_q <= mem[sel_addr];
  end

  // Visit marking is a two-cycle read-modify-write; the previous mark is forwarded
  // so back-to-back writes to one cell count once.
  assign cell_now = (last_mark_q && (last_addr_q == wr_addr_q)) ? SEEN : rd_q;
  assign mark     = wr_pend_q && (cell_now == FREE);
  assign wall_hit = wr_pend_q && (cell_now == WALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend_q   <= 1'b0;
      last_mark_q <= 1'b0;
    end else begin
      wr_pend_q   <= (state_q == RUN) && maze_we;
      last_mark_q <= mark;
    end
    wr_addr_q   <= sel_addr;
    last_addr_q <= wr_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst || load_begin) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (mark && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
      if (wall_hit)                   err_q <= 1'b1;
    end
  end

  // Marking only turns free into visited, so the wall bit read here is never stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      rd_valid_q <= (state_q == RUN) && maze_oe;
      if (rd_valid_q) hold_q <= (rd_q == WALL);
      if (((state_q == IDLE) || (state_q == LOAD)) && maze_oe) hold_q <= 1'b1;
    end
  end

  assign maze_in        = rd_valid_q ? (rd_q == WALL) : hold_q;
  assign visited_count  = cnt_q;
  assign wall_write_err = err_q;

endmodule

// File: tb/tb_maze_ram.sv
// Bench for maze_ram: directed and randomized solver traffic against an array model
// of the maze that applies the load / read / mark-visited rules directly.
module tb_maze_ram;
  localparam int DIM   = 64;
  localparam int AW    = 6;
  localparam int CELLS = DIM * DIM;

  logic            clk = 1'b0;
  logic            rst, load_start, load_valid, load_data, load_ready;
  logic [AW-1:0]   row, col;
  logic            maze_oe, maze_we, done;
  logic            maze_in, loaded, finished, wall_write_err;
  logic [2*AW:0]   visited_count;

  always #5 clk = ~clk;

  maze_ram #(.DIM(DIM), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .done(done), .maze_in(maze_in),
    .loaded(loaded), .finished(finished), .visited_count(visited_count),
    .wall_write_err(wall_write_err)
  );

  int checks = 0;
  int errors = 0;
  int cells [CELLS];
  int image [CELLS];
  int phase;            // 0 idle, 1 loading, 2 solver running, 3 finished
  int m_addr, m_cnt, dut_hs;
  bit m_err, exp_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_load_ready", load_ready, 0);
    check("rst_loaded", loaded, 0);
    check("rst_finished", finished, 0);
    check("rst_maze_in", maze_in, 1);
    check("rst_visited", visited_count, 0);
    check("rst_err", wall_write_err, 0);
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    if (phase != 2) begin
      phase  = 1;
      m_addr = 0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end
    step();
    load_start = 1'b0;
    $display("txn load_start phase=%0d", phase);
  endtask

  // valid toggles every other cycle; stops after n accepted beats or when loading ends
  task automatic load_cells(input int n);
    bit v = 1'b0;
    int acc = 0;
    while (acc < n && phase == 1) begin
      v          = !v;
      load_valid = v;
      load_data  = (image[m_addr] == 1);
      if (load_valid && load_ready) dut_hs++;
      if (v) begin
        cells[m_addr] = image[m_addr];
        m_addr++;
        acc++;
        if (m_addr == CELLS) phase = 2;
      end
      step();
    end
    load_valid = 1'b0;
    $display("txn load beats=%0d addr=%0d loaded=%0b", acc, m_addr, loaded);
  endtask

  task automatic solver_cycle(input bit oe, input bit we, input bit dn, input int r, input int c);
    int idx;
    idx     = r * DIM + c;
    row     = r[AW-1:0];
    col     = c[AW-1:0];
    maze_oe = oe;
    maze_we = we;
    done    = dn;
    if (phase == 2) begin
      if (oe) exp_in = (cells[idx] == 1);
      if (we) begin
        if (cells[idx] == 0) begin
          cells[idx] = 2;
          if (m_cnt < CELLS) m_cnt++;
        end else if (cells[idx] == 1) begin
          m_err = 1'b1;
        end
      end
      if (dn) phase = 3;
    end else if (phase != 3 && oe) begin
      exp_in = 1'b1;
    end
    step();
    maze_oe = 1'b0;
    maze_we = 1'b0;
    done    = 1'b0;
    $display("txn oe=%0b we=%0b done=%0b r=%0d c=%0d maze_in=%0b", oe, we, dn, r, c, maze_in);
    check("maze_in", maze_in, exp_in);
    check("finished", finished, phase == 3);
  endtask

  task automatic drain_and_check_counts();
    solver_cycle(0, 0, 0, 0, 0);
    solver_cycle(0, 0, 0, 0, 0);
    check("visited_count", visited_count, m_cnt);
    check("wall_write_err", wall_write_err, m_err);
  endtask

  task automatic build_image(input bit rand_walls);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        if (r == 0 || r == DIM - 1 || c == 0 || c == DIM - 1)
          image[r * DIM + c] = (r == 0 && c == 5) ? 0 : 1;
        else
          image[r * DIM + c] = rand_walls ? int'($urandom_range(0, 3) == 0) : 0;
      end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 1'b0;
    row = '0; col = '0; maze_oe = 1'b0; maze_we = 1'b0; done = 1'b0;
    phase = 0; m_addr = 0; m_cnt = 0; m_err = 1'b0; exp_in = 1'b1; dut_hs = 0;
    step();
    step();
    rst = 1'b0;
    check_reset_values();
    solver_cycle(1, 1, 0, 0, 0);

    // bordered maze with the entrance at (0,5)
    build_image(1'b0);
    pulse_load_start();
    check("load_ready_in_load", load_ready, 1);
    check("loaded_in_load", loaded, 0);
    dut_hs = 0;
    load_cells(CELLS);
    check("handshakes", dut_hs, CELLS);
    check("loaded_after_last", loaded, 1);
    check("ready_after_last", load_ready, 0);
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (load_valid && load_ready) dut_hs++;
      step();
    end
    load_valid = 1'b0;
    check("handshakes_after", dut_hs, CELLS);

    solver_cycle(1, 0, 0, 0, 0);
    solver_cycle(1, 0, 0, 0, 5);
    for (int i = 0; i < 5; i++) solver_cycle(0, 0, 0, 0, 0);

    solver_cycle(0, 1, 0, 10, 10);
    solver_cycle(0, 1, 0, 10, 10);
    solver_cycle(0, 1, 0, 10, 11);
    drain_and_check_counts();
    solver_cycle(1, 1, 0, 12, 12);
    drain_and_check_counts();

    pulse_load_start();
    check("run_ignores_start", loaded, 1);

    // random traffic in a small corner to stress back-to-back marks and wall hits
    for (int i = 0; i < 400; i++)
      solver_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    drain_and_check_counts();

    solver_cycle(0, 1, 0, 0, 0);
    drain_and_check_counts();
    solver_cycle(1, 0, 0, 0, 0);

    solver_cycle(1, 0, 0, 0, 5);
    solver_cycle(0, 1, 1, 20, 20);
    solver_cycle(1, 1, 0, 0, 0);
    solver_cycle(0, 1, 0, 21, 21);
    drain_and_check_counts();

    pulse_load_start();
    check("reload_ready", load_ready, 1);
    check("reload_loaded", loaded, 0);
    check("reload_count", visited_count, 0);
    check("reload_err", wall_write_err, 0);
    solver_cycle(1, 0, 0, 3, 3);

    // abandoned load, reset, restarted load, then a complete one
    build_image(1'b1);
    load_cells(2000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    phase = 0; m_addr = 0; m_cnt = 0; m_err = 1'b0; exp_in = 1'b1;
    check_reset_values();
    pulse_load_start();
    load_cells(100);
    pulse_load_start();
    load_cells(CELLS - 1);
    check("loaded_before_last", loaded, 0);
    load_cells(1);
    check("loaded_full_reload", loaded, 1);

    solver_cycle(1, 1, 0, 10, 10);
    drain_and_check_counts();
    for (int i = 0; i < 300; i++)
      solver_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                   int'($urandom_range(0, DIM - 1)), int'($urandom_range(0, DIM - 1)));
    drain_and_check_counts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
